estado_mascota: RTL
===================

# estado_mascota

Pet-state evaluator that sits directly downstream of the four-need level tracker. It consumes the four 2-bit need levels (Animo, Energia, Descanso, Medicina) and classifies them into a single 3-bit expression code for the display stage. It raises an alert when any need is empty and latches a death condition when two or more needs stay empty for a configurable time. It also provides a test mode, toggled by `B_Test`, that steps through every expression code.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per one-second tick.
- `T_CRITICO`, default 10: consecutive seconds with ≥2 empty needs before death.
- `T_TEST`, default 2: seconds each code is shown in test mode.

Ports:
- `clk`, input, 1: single system clock; all logic on rising edge.
- `B_Reset`, input, 1: synchronous, active-low reset.
- `B_Test`, input, 1: raw test button, active-high, asynchronous to `clk`.
- `Nivel_Animo`, input, 2: mood level, 0..3.
- `Nivel_Energia`, input, 2: energy level, 0..3.
- `Nivel_Descanso`, input, 2: rest level, 0..3.
- `Nivel_Medicina`, input, 2: health level, 0..3.
- `Estado`, output, 3: expression code.
- `Alerta`, output, 1: high while any level is 0 (NORMAL mode only).
- `Muerto`, output, 1: sticky death flag.
- `Cambio`, output, 1: one-cycle pulse when `Estado` changes value.

## Operation

Expression codes:
- NEUTRAL = 0, FELIZ = 1, HAMBRIENTO = 2, CANSADO = 3, ENFERMO = 4, TRISTE = 5, MUERTO = 6.
- Code 7 is never driven.

Mode FSM:
- States are NORMAL, TEST and DEAD. Reset enters NORMAL.
- NORMAL → TEST on a `B_Test` rising edge.
- TEST → NORMAL on the next `B_Test` rising edge.
- NORMAL → DEAD when the critical counter reaches `T_CRITICO`.
- DEAD is exited only by reset. `B_Test` is ignored in DEAD.

Classification in NORMAL (first match wins):
- Medicina == 0 → ENFERMO.
- Energia == 0 → HAMBRIENTO.
- Descanso == 0 → CANSADO.
- Animo == 0 → TRISTE.
- All four == 3 → FELIZ.
- Otherwise → NEUTRAL.

Critical counter:
- `zeros` is the count of levels equal to 0.
- On each tick in NORMAL: if `zeros` ≥ 2, increment, saturating at `T_CRITICO`; otherwise clear to 0.
- A clear also happens immediately on any cycle with `zeros` < 2, without waiting for a tick.
- In TEST the counter holds its value.
- Counter width is $clog2(T_CRITICO+1).

TEST mode:
- On entry, `Estado` = 0.
- Every `T_TEST` ticks, `Estado` increments. It wraps from 6 to 0.
- `Alerta` = 0 throughout.
- On exit, the classifier resumes on the next cycle.

DEAD:
- `Estado` = MUERTO, `Muerto` = 1, `Alerta` = 0, frozen until reset.

Prescaler:
- Counts 0..`TICKS_PER_SEC`−1 and emits a one-cycle tick on wrap.
- Free-running in all modes.

`B_Test` input path:
- A 2-flop synchronizer, then a registered previous value.
- A rising edge is sync == 1 && prev == 0.

## Timing

- Reset values (when `B_Reset` = 0 at a clock edge): `Estado` = 0, `Alerta` = 0, `Muerto` = 0, `Cambio` = 0. The mode, prescaler, critical counter, test step counter, synchronizer and edge registers are also cleared.
- Reset mid-operation, including in DEAD or TEST, returns to NORMAL on the next edge.
- All outputs are registered.
- `Estado` and `Alerta` reflect the levels sampled at edge N from edge N+1 (1-cycle latency).
- `B_Test` reaches the mode FSM 3 edges after its rising transition. A level held high produces one edge only.
- `Cambio` is high in the cycle after `Estado` takes a new value, for exactly one cycle. Reset itself produces no pulse.
- Death: `Muerto` and `Estado` = 6 appear the edge after the tick on which the counter reaches `T_CRITICO`.
- Simultaneous events:
  - Death and a `B_Test` edge on the same edge: death wins.
  - Tick and a `B_Test` edge on the same edge: the mode change wins, and that tick does not advance the test step or the critical counter.

## Test plan

Use `TICKS_PER_SEC` = 4, `T_CRITICO` = 3, `T_TEST` = 2.

- **Reset:** hold `B_Reset` = 0 with levels = 3,3,3,3 → `Estado` = 0, `Alerta` = 0, `Muerto` = 0, `Cambio` = 0. One cycle after release → `Estado` = 1 (FELIZ), with `Cambio` pulsing for one cycle.
- **Priority:** levels Animo = 0, Energia = 0, Descanso = 1, Medicina = 2 → `Estado` = 2, `Alerta` = 1. Then set Medicina = 0 → `Estado` = 4 one cycle later.
- **Death:** hold Energia = 0 and Descanso = 0 for 3 ticks (12 cycles) → `Muerto` = 1 and `Estado` = 6 one edge after the 3rd tick. Restoring the levels or pulsing `B_Test` leaves both unchanged. Reset clears them.
- **Counter clear:** hold two zeros for 2 ticks, restore one level for 1 cycle, then hold two zeros for 2 more ticks → `Muerto` stays 0.
- **Test mode:** a `B_Test` pulse → `Estado` = 0 three edges later, then steps 1, 2, … every 8 cycles, wrapping 6 → 0. A second pulse → the classifier output returns.
- **Freeze:** accumulate 2 critical ticks, enter TEST for 20 cycles, exit while keeping two levels at 0 → `Muerto` = 1 after exactly 1 further tick.

Source files
------------

// File: rtl/estado_mascota.sv
`default_nettype none
// ============================================================================
// estado_mascota : turns four 2-bit need levels into an expression code,
//                  with alert, sticky death and a code-stepping test mode.
// Revision 1.0
// ============================================================================
module estado_mascota #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int T_CRITICO     = 10,
   parameter int T_TEST        = 2
) (
   input  logic       clk,
   input  logic       B_Reset,
   input  logic       B_Test,
   input  logic [1:0] Nivel_Animo,
   input  logic [1:0] Nivel_Energia,
   input  logic [1:0] Nivel_Descanso,
   input  logic [1:0] Nivel_Medicina,
   output logic [2:0] Estado,
   output logic       Alerta,
   output logic       Muerto,
   output logic       Cambio
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int CW = $clog2(T_CRITICO + 1);
   localparam int SW = (T_TEST > 1) ? $clog2(T_TEST) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [CW-1:0] CRIT_MAX  = CW'(T_CRITICO);
   localparam logic [SW-1:0] STEP_MAX  = SW'(T_TEST - 1);

   localparam logic [2:0] C_NEUTRAL    = 3'd0;
   localparam logic [2:0] C_FELIZ      = 3'd1;
   localparam logic [2:0] C_HAMBRIENTO = 3'd2;
   localparam logic [2:0] C_CANSADO    = 3'd3;
   localparam logic [2:0] C_ENFERMO    = 3'd4;
   localparam logic [2:0] C_TRISTE     = 3'd5;
   localparam logic [2:0] C_MUERTO     = 3'd6;

   typedef enum logic [1:0] {
      S_NORMAL = 2'd0,
      S_TEST   = 2'd1,
      S_DEAD   = 2'd2
   } mode_t;

   mode_t           mode_q, mode_d;
   logic [PW-1:0]   presc_q;
   logic [CW-1:0]   crit_q, crit_d;
   logic [SW-1:0]   step_q, step_d;
   logic [2:0]      estado_q, estado_d;
   logic            alerta_q, alerta_d;
   logic            muerto_q, muerto_d;
   logic            cambio_q;
   logic            sync1_q, sync2_q, prev_q;

   logic            w_tick;
   logic            w_flanco;
   logic [2:0]      w_zeros;
   logic            w_dos_ceros;
   logic            w_alguno;
   logic [2:0]      w_clase;

   assign w_tick   = (presc_q == PRESC_MAX);
   assign w_flanco = sync2_q & ~prev_q;

   always_ff @(posedge clk) begin
      if (!B_Reset) begin
         presc_q <= '0;
      end else if (w_tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   // Button is asynchronous: two flops for metastability, a third for edge detection.
   always_ff @(posedge clk) begin
      if (!B_Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= B_Test;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign w_zeros = 3'(Nivel_Animo    == 2'd0) + 3'(Nivel_Energia  == 2'd0)
                  + 3'(Nivel_Descanso == 2'd0) + 3'(Nivel_Medicina == 2'd0);
   assign w_dos_ceros = (w_zeros >= 3'd2);
   assign w_alguno    = (w_zeros != 3'd0);

   always_comb begin
      w_clase = C_NEUTRAL;
      if (Nivel_Medicina == 2'd0) begin
         w_clase = C_ENFERMO;
      end else if (Nivel_Energia == 2'd0) begin
         w_clase = C_HAMBRIENTO;
      end else if (Nivel_Descanso == 2'd0) begin
         w_clase = C_CANSADO;
      end else if (Nivel_Animo == 2'd0) begin
         w_clase = C_TRISTE;
      end else if ((Nivel_Animo == 2'd3) && (Nivel_Energia == 2'd3) &&
                   (Nivel_Descanso == 2'd3) && (Nivel_Medicina == 2'd3)) begin
         w_clase = C_FELIZ;
      end
   end

   always_comb begin
      mode_d   = mode_q;
      crit_d   = crit_q;
      step_d   = step_q;
      estado_d = estado_q;
      alerta_d = alerta_q;
      muerto_d = muerto_q;
      case (mode_q)
         S_NORMAL: begin
            if (crit_q == CRIT_MAX) begin
               // Death outranks a coincident button edge.
               mode_d   = S_DEAD;
               estado_d = C_MUERTO;
               alerta_d = 1'b0;
               muerto_d = 1'b1;
            end else begin
               if (!w_dos_ceros) begin
                  crit_d = '0;
               end else if (w_tick && !w_flanco) begin
                  crit_d = crit_q + 1'b1;
               end
               if (w_flanco) begin
                  mode_d   = S_TEST;
                  estado_d = C_NEUTRAL;
                  alerta_d = 1'b0;
                  step_d   = '0;
               end else begin
                  estado_d = w_clase;
                  alerta_d = w_alguno;
               end
            end
         end
         S_TEST: begin
            alerta_d = 1'b0;
            if (w_flanco) begin
               mode_d   = S_NORMAL;
               estado_d = w_clase;
               alerta_d = w_alguno;
            end else if (w_tick) begin
               if (step_q == STEP_MAX) begin
                  step_d   = '0;
                  estado_d = (estado_q == C_MUERTO) ? C_NEUTRAL : estado_q + 3'd1;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         S_DEAD: begin
            estado_d = C_MUERTO;
            alerta_d = 1'b0;
            muerto_d = 1'b1;
         end
         default: begin
            mode_d = S_NORMAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!B_Reset) begin
         mode_q   <= S_NORMAL;
         crit_q   <= '0;
         step_q   <= '0;
         estado_q <= C_NEUTRAL;
         alerta_q <= 1'b0;
         muerto_q <= 1'b0;
         cambio_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         crit_q   <= crit_d;
         step_q   <= step_d;
         estado_q <= estado_d;
         alerta_q <= alerta_d;
         muerto_q <= muerto_d;
         cambio_q <= (estado_d != estado_q);
      end
   end

   assign Estado = estado_q;
   assign Alerta = alerta_q;
   assign Muerto = muerto_q;
   assign Cambio = cambio_q;

endmodule
`default_nettype wire
